// File: rtl/pcie_tx_lane_striper.sv
// PHY TX lane striper: accepts multi-byte MAC beats over valid/ready, stripes them
// across a run-time link width and periodically inserts SKP ordered sets.
module pcie_tx_lane_striper #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_LANES    = 4,
    parameter int SKP_INTERVAL = 1180
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         link_en_i,
    input  logic [$clog2(NUM_LANES):0]   link_width_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic [DATA_WIDTH/8-1:0]      data_k_i,
    input  logic                         data_valid_i,
    output logic                         data_ready_o,
    output logic [NUM_LANES*8-1:0]       lane_data_o,
    output logic [NUM_LANES-1:0]         lane_k_o,
    output logic [NUM_LANES-1:0]         lane_valid_o,
    output logic                         skp_active_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LW    = $clog2(NUM_LANES);
    localparam int SW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CW    = $clog2(SKP_INTERVAL);

    localparam logic [LW:0]   WIDTH_MAX = (LW+1)'(LW);
    localparam logic [CW-1:0] CNT_MAX   = CW'(SKP_INTERVAL - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(SKP_INTERVAL - 2);
    localparam logic [7:0]    K_COM     = 8'hBC;
    localparam logic [7:0]    K_SKP     = 8'h1C;

    typedef enum logic [1:0] {IDLE, STREAM, SKP} state_t;

    state_t                  state_q, state_d;
    logic [LW:0]             width_q;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [BYTES-1:0]        hold_k;
    logic                    hold_vld;
    logic [SW-1:0]           slice_q;
    logic [SW-1:0]           last_idx;
    logic                    last_slice;
    logic [CW-1:0]           skp_cnt;
    logic                    skp_due;
    logic [1:0]              skp_idx;
    logic                    accept;
    int                      w_lanes;

    logic [NUM_LANES*8-1:0]  lane_data_p0, lane_data_p1;
    logic [NUM_LANES-1:0]    lane_k_p0, lane_k_p1;
    logic [NUM_LANES-1:0]    vld_p0, vld_p1;
    logic                    skp_active_p0, skp_active_p1;

    function automatic logic [LW:0] clamp_width(input logic [LW:0] w);
        return (w > WIDTH_MAX) ? WIDTH_MAX : w;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    assign w_lanes    = 1 << width_q;
    assign last_idx   = SW'((BYTES >> width_q) - 1);
    assign last_slice = (slice_q == last_idx);

    // Ready looks only at registered state so upstream never sees a combinational loop.
    always_comb begin
        data_ready_o = (state_q == STREAM) && !skp_due && (!hold_vld || last_slice);
        accept       = data_ready_o && data_valid_i;
    end

    always_comb begin
        state_d = state_q;
        if (!link_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = STREAM;
                STREAM:  if (skp_due && (!hold_vld || last_slice)) state_d = SKP;
                SKP:     if (skp_idx == 2'd3) state_d = STREAM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Width only moves between beats so a beat is never striped at two widths.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                              width_q <= '0;
        else if (!hold_vld && state_q != SKP)    width_q <= clamp_width(link_width_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_vld <= 1'b0;
            slice_q  <= '0;
        end else if (!link_en_i) begin
            hold_vld <= 1'b0;
            slice_q  <= '0;
        end else if (accept) begin
            hold_vld <= 1'b1;
            slice_q  <= '0;
        end else if (state_q == STREAM && hold_vld) begin
            if (last_slice) hold_vld <= 1'b0;
            else            slice_q  <= slice_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            hold_data <= data_i;
            hold_k    <= data_k_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            skp_cnt <= '0;
            skp_due <= 1'b0;
            skp_idx <= 2'd0;
        end else if (!link_en_i) begin
            skp_cnt <= '0;
            skp_due <= 1'b0;
            skp_idx <= 2'd0;
        end else begin
            skp_idx <= (state_q == SKP) ? skp_idx + 2'd1 : 2'd0;
            if (state_q != SKP && state_d == SKP) begin
                skp_cnt <= '0;
                skp_due <= 1'b0;
            end else if (state_q != IDLE) begin
                skp_cnt <= sat_inc(skp_cnt);
                if (skp_cnt == CNT_PRE) skp_due <= 1'b1;
            end
        end
    end

    // p0: select the slice or ordered-set symbol for each active lane
    always_comb begin
        lane_data_p0  = '0;
        lane_k_p0     = '0;
        vld_p0        = '0;
        skp_active_p0 = 1'b0;
        if (link_en_i && state_q == STREAM && hold_vld) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (l < w_lanes) begin
                    lane_data_p0[8*l +: 8] = hold_data[8*(int'(slice_q)*w_lanes + l) +: 8];
                    lane_k_p0[l]           = hold_k[int'(slice_q)*w_lanes + l];
                    vld_p0[l]              = 1'b1;
                end
            end
        end else if (link_en_i && state_q == SKP) begin
            skp_active_p0 = 1'b1;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (l < w_lanes) begin
                    lane_data_p0[8*l +: 8] = (skp_idx == 2'd0) ? K_COM : K_SKP;
                    lane_k_p0[l]           = 1'b1;
                    vld_p0[l]              = 1'b1;
                end
            end
        end
    end

    // p1: registered lane outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lane_data_p1  <= '0;
            lane_k_p1     <= '0;
            vld_p1        <= '0;
            skp_active_p1 <= 1'b0;
        end else begin
            lane_data_p1  <= lane_data_p0;
            lane_k_p1     <= lane_k_p0;
            vld_p1        <= vld_p0;
            skp_active_p1 <= skp_active_p0;
        end
    end

    assign lane_data_o  = lane_data_p1;
    assign lane_k_o     = lane_k_p1;
    assign lane_valid_o = vld_p1;
    assign skp_active_o = skp_active_p1;

endmodule

// File: tb/tb_pcie_tx_lane_striper.sv
// Directed bench for pcie_tx_lane_striper: x1/x2/x4 striping, width latching,
// link drop, SKP insertion every 16 cycles and asynchronous reset.
module tb_pcie_tx_lane_striper;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        link_en_i = 1'b0;
    logic [2:0]  link_width_i = 3'd0;
    logic [31:0] data_i = 32'h0;
    logic [3:0]  data_k_i = 4'h0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [31:0] lane_data_o;
    logic [3:0]  lane_k_o;
    logic [3:0]  lane_valid_o;
    logic        skp_active_o;

    int tests_run = 0;
    int tests_failed = 0;

    pcie_tx_lane_striper #(
        .DATA_WIDTH  (32),
        .NUM_LANES   (4),
        .SKP_INTERVAL(16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .link_en_i   (link_en_i),
        .link_width_i(link_width_i),
        .data_i      (data_i),
        .data_k_i    (data_k_i),
        .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o),
        .lane_data_o (lane_data_o),
        .lane_k_o    (lane_k_o),
        .lane_valid_o(lane_valid_o),
        .skp_active_o(skp_active_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] beat(input int n);
        return {8'(4*n+4), 8'(4*n+3), 8'(4*n+2), 8'(4*n+1)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_link(input logic [2:0] w);
        data_valid_i = 1'b0;
        link_en_i    = 1'b0;
        tick();
        link_width_i = w;
        link_en_i    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        data_valid_i = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (lane_data_o !== 32'h0 || lane_k_o !== 4'h0 || lane_valid_o !== 4'h0 || skp_active_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: data=%h k=%b vld=%b skp=%b required all zero", lane_data_o, lane_k_o, lane_valid_o, skp_active_o);
        end
        tests_run++;
        if (data_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b required 0", data_ready_o);
        end
        rst_i = 1'b1;
        tick();
        tests_run++;
        if (data_ready_o !== 1'b0 || lane_valid_o !== 4'h0) begin
            tests_failed++;
            $display("FAIL idle_disabled: ready=%b vld=%b required 0/0000", data_ready_o, lane_valid_o);
        end
        data_valid_i = 1'b0;
    endtask

    task automatic test_x4_single();
        start_link(3'd2);
        tests_run++;
        if (data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL x4_ready_empty: got %b required 1", data_ready_o);
        end
        data_i = 32'h44332211; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tests_run++;
        if (lane_valid_o !== 4'h0) begin
            tests_failed++;
            $display("FAIL x4_latency: vld=%b required 0000 on accept edge", lane_valid_o);
        end
        tick();
        tests_run++;
        if (lane_data_o !== 32'h44332211 || lane_valid_o !== 4'hF || lane_k_o !== 4'h0) begin
            tests_failed++;
            $display("FAIL x4_stripe: data=%h vld=%b k=%b required 44332211/1111/0000", lane_data_o, lane_valid_o, lane_k_o);
        end
        tick();
        tests_run++;
        if (lane_valid_o !== 4'h0) begin
            tests_failed++;
            $display("FAIL x4_single_cycle: vld=%b required 0000", lane_valid_o);
        end
    endtask

    task automatic test_x2_back_to_back();
        logic [31:0] exp_data [4];
        logic        exp_rdy [4];
        exp_data = '{32'h0000BBAA, 32'h0000DDCC, 32'h00002211, 32'h00004433};
        exp_rdy  = '{1'b1, 1'b0, 1'b1, 1'b1};
        start_link(3'd1);
        data_i = 32'hDDCCBBAA; data_valid_i = 1'b1;
        tick();
        data_i = 32'h44332211;
        tests_run++;
        if (data_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL x2_ready_mid: got %b required 0", data_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) data_valid_i = 1'b0;
            tests_run++;
            if (lane_data_o !== exp_data[i] || lane_valid_o !== 4'b0011 || data_ready_o !== exp_rdy[i]) begin
                tests_failed++;
                $display("FAIL x2_slice%0d: data=%h vld=%b rdy=%b required %h/0011/%b", i, lane_data_o, lane_valid_o, data_ready_o, exp_data[i], exp_rdy[i]);
            end
        end
        tick();
        tests_run++;
        if (lane_valid_o !== 4'h0) begin
            tests_failed++;
            $display("FAIL x2_drained: vld=%b required 0000", lane_valid_o);
        end
    endtask

    task automatic test_x1_k_symbol();
        logic [31:0] exp_data [4];
        logic [3:0]  exp_k [4];
        logic        exp_rdy [4];
        exp_data = '{32'h000000BC, 32'h0, 32'h0, 32'h0};
        exp_k    = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        exp_rdy  = '{1'b0, 1'b0, 1'b1, 1'b1};
        start_link(3'd0);
        data_i = 32'h000000BC; data_k_i = 4'b0001; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0; data_k_i = 4'h0;
        tests_run++;
        if (data_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL x1_ready_accept: got %b required 0", data_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (lane_data_o !== exp_data[i] || lane_k_o !== exp_k[i] || lane_valid_o !== 4'b0001 || data_ready_o !== exp_rdy[i]) begin
                tests_failed++;
                $display("FAIL x1_slice%0d: data=%h k=%b vld=%b rdy=%b required %h/%b/0001/%b", i, lane_data_o, lane_k_o, lane_valid_o, data_ready_o, exp_data[i], exp_k[i], exp_rdy[i]);
            end
        end
    endtask

    task automatic test_width_clamp();
        start_link(3'd7);
        data_i = 32'h0D0C0B0A; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        tests_run++;
        if (lane_data_o !== 32'h0D0C0B0A || lane_valid_o !== 4'hF) begin
            tests_failed++;
            $display("FAIL width_clamp: data=%h vld=%b required 0d0c0b0a/1111", lane_data_o, lane_valid_o);
        end
    endtask

    task automatic test_width_change();
        start_link(3'd1);
        data_i = 32'hDDCCBBAA; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        link_width_i = 3'd0;
        tick();
        tests_run++;
        if (lane_data_o !== 32'h0000BBAA || lane_valid_o !== 4'b0011) begin
            tests_failed++;
            $display("FAIL wchg_old0: data=%h vld=%b required 0000bbaa/0011", lane_data_o, lane_valid_o);
        end
        tick();
        tests_run++;
        if (lane_data_o !== 32'h0000DDCC || lane_valid_o !== 4'b0011) begin
            tests_failed++;
            $display("FAIL wchg_old1: data=%h vld=%b required 0000ddcc/0011", lane_data_o, lane_valid_o);
        end
        data_i = 32'h44332211; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        tests_run++;
        if (lane_data_o !== 32'h00000011 || lane_valid_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wchg_new0: data=%h vld=%b required 00000011/0001", lane_data_o, lane_valid_o);
        end
        tick();
        tests_run++;
        if (lane_data_o !== 32'h00000022 || lane_valid_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wchg_new1: data=%h vld=%b required 00000022/0001", lane_data_o, lane_valid_o);
        end
    endtask

    task automatic test_link_drop();
        start_link(3'd0);
        repeat (10) tick();
        data_i = 32'h44332211; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        tests_run++;
        if (lane_data_o !== 32'h00000011 || lane_valid_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL drop_pre: data=%h vld=%b required 00000011/0001", lane_data_o, lane_valid_o);
        end
        link_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (lane_valid_o !== 4'h0 || lane_data_o !== 32'h0 || data_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL drop_idle%0d: vld=%b data=%h rdy=%b required 0000/0/0", i, lane_valid_o, lane_data_o, data_ready_o);
            end
        end
        link_en_i = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            tests_run++;
            if (lane_valid_o !== 4'h0 || skp_active_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL drop_restart%0d: vld=%b skp=%b required 0000/0", i, lane_valid_o, skp_active_o);
            end
        end
        tests_run++;
        if (data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_ready: got %b required 1", data_ready_o);
        end
    endtask

    task automatic test_skp_insertion();
        int         n;
        int         exp_beat;
        logic       rdy;
        logic       is_skp;
        logic [7:0] sym;
        n = 0;
        exp_beat = 0;
        start_link(3'd2);
        for (int c = 0; c < 34; c++) begin
            is_skp = (c >= 17 && c <= 20) || (c >= 33);
            sym    = (c == 17 || c == 33) ? 8'hBC : 8'h1C;
            tests_run++;
            if (skp_active_o !== is_skp) begin
                tests_failed++;
                $display("FAIL skp_flag_c%0d: got %b required %b", c, skp_active_o, is_skp);
            end
            if (is_skp) begin
                tests_run++;
                if (lane_data_o !== {4{sym}} || lane_k_o !== 4'hF || lane_valid_o !== 4'hF) begin
                    tests_failed++;
                    $display("FAIL skp_sym_c%0d: data=%h k=%b vld=%b required %h/1111/1111", c, lane_data_o, lane_k_o, lane_valid_o, {4{sym}});
                end
            end else if (lane_valid_o === 4'hF) begin
                tests_run++;
                if (lane_data_o !== beat(exp_beat) || lane_k_o !== 4'h0) begin
                    tests_failed++;
                    $display("FAIL skp_data_c%0d: data=%h k=%b required %h/0000", c, lane_data_o, lane_k_o, beat(exp_beat));
                end
                exp_beat++;
            end else begin
                tests_run++;
                if (lane_valid_o !== 4'h0) begin
                    tests_failed++;
                    $display("FAIL skp_partial_c%0d: vld=%b required 0000 or 1111", c, lane_valid_o);
                end
            end
            if ((c >= 15 && c <= 19) || c >= 31) begin
                tests_run++;
                if (data_ready_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL skp_ready_c%0d: got %b required 0", c, data_ready_o);
                end
            end
            if (c == 20) begin
                tests_run++;
                if (data_ready_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL skp_resume: got %b required 1", data_ready_o);
                end
            end
            data_i = beat(n);
            data_valid_i = 1'b1;
            rdy = data_ready_o;
            tick();
            if (rdy) n++;
        end
        tests_run++;
        if (n != 26 || exp_beat != 26) begin
            tests_failed++;
            $display("FAIL skp_beat_count: accepted=%0d emitted=%0d required 26/26", n, exp_beat);
        end
        // Asynchronous reset in the middle of the second ordered set.
        #3 rst_i = 1'b0;
        #1;
        data_valid_i = 1'b0;
        tests_run++;
        if (lane_valid_o !== 4'h0 || lane_data_o !== 32'h0 || skp_active_o !== 1'b0 || data_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: vld=%b data=%h skp=%b rdy=%b required all zero", lane_valid_o, lane_data_o, skp_active_o, data_ready_o);
        end
        #2 rst_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (lane_valid_o !== 4'h0 || skp_active_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset%0d: vld=%b skp=%b required 0000/0", i, lane_valid_o, skp_active_o);
            end
        end
        tests_run++;
        if (data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready: got %b required 1", data_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_x4_single();
        test_x2_back_to_back();
        test_x1_k_symbol();
        test_width_clamp();
        test_width_change();
        test_link_drop();
        test_skp_insertion();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
